bp_update_scheduler: RTL and testbench

// - Owns the single port of the predictor table: local ctr, global ctr, chooser ctr.
// - Arbitrates fetch-stage lookups against resolved-branch updates from EX.
// - Buffers updates in a FIFO and drains each one as read-modify-write over two cycles.
// - Stalls fetch when the FIFO is full or the head update has aged out.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_sat_counter2.sv | 18 +
 rtl/bp_update_scheduler.sv | 176 +++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the predictor-table update scheduler.
package bp_pkg;

    localparam int BP_IDX_W = 5;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
        logic                local_ok;
        logic                global_ok;
    } bp_upd_t;

    // Packing matches the table word: {chooser, global, local}
    typedef struct packed {
        logic [1:0] chooser;
        logic [1:0] glb;
        logic [1:0] loc;
    } bp_ctrs_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_RD = 2'd1,
        UPD_WR = 2'd2
    } bp_sched_state_e;

endpackage

// File: rtl/bp_sat_counter2.sv
// Two-bit saturating up/down counter step.
module bp_sat_counter2 (
    input  logic       inc,
    input  logic       dec,
    input  logic [1:0] cur,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != 2'd3) begin
            nxt = cur + 2'd1;
        end else if (dec && !inc && cur != 2'd0) begin
            nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Single-port predictor table owner: fetch lookups vs queued
// read-modify-write counter updates from EX.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int IDX_W   = BP_IDX_W,
    parameter int DEPTH   = 4,
    parameter int AGE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_req,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_grant,
    output logic             fetch_stall,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_local_ok,
    input  logic             upd_global_ok,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_idx,
    output logic [5:0]       tbl_wdata,
    input  logic [5:0]       tbl_rdata,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    bp_sched_state_e  state_q, state_d;
    bp_upd_t          fifo_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    bp_ctrs_t         rd_q, rd_d;

    bp_upd_t  head;
    bp_upd_t  upd_in;
    logic     push;
    logic     pop;
    logic     forced;
    logic     queued;
    logic [1:0] loc_nxt;
    logic [1:0] glb_nxt;
    logic [1:0] cho_nxt;

    assign head   = fifo_q[head_q];
    assign upd_in = '{idx:       BP_IDX_W'(upd_idx),
                      taken:     upd_taken,
                      local_ok:  upd_local_ok,
                      global_ok: upd_global_ok};

    assign queued    = (count_q != '0);
    assign upd_ready = (count_q < CNT_W'(DEPTH));
    assign push      = upd_valid && upd_ready;
    assign pop       = (state_q == UPD_WR);
    assign forced    = (count_q == CNT_W'(DEPTH))
                     || (queued && age_q >= AGE_W'(AGE_MAX));
    assign busy      = queued || (state_q != IDLE);

    bp_sat_counter2 u_loc (
        .inc (head.taken),
        .dec (!head.taken),
        .cur (rd_q.loc),
        .nxt (loc_nxt)
    );

    bp_sat_counter2 u_glb (
        .inc (head.taken),
        .dec (!head.taken),
        .cur (rd_q.glb),
        .nxt (glb_nxt)
    );

    bp_sat_counter2 u_cho (
        .inc (head.global_ok && !head.local_ok),
        .dec (head.local_ok && !head.global_ok),
        .cur (rd_q.chooser),
        .nxt (cho_nxt)
    );

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        tbl_en       = 1'b0;
        tbl_we       = 1'b0;
        tbl_idx      = '0;
        tbl_wdata    = '0;
        lookup_grant = 1'b0;
        fetch_stall  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (forced || (!lookup_req && queued)) begin
                    tbl_en      = 1'b1;
                    tbl_idx     = IDX_W'(head.idx);
                    fetch_stall = lookup_req;
                    state_d     = UPD_RD;
                end else if (lookup_req) begin
                    tbl_en       = 1'b1;
                    tbl_idx      = lookup_idx;
                    lookup_grant = 1'b1;
                end
            end
            UPD_RD: begin
                fetch_stall = lookup_req;
                rd_d        = bp_ctrs_t'(tbl_rdata);
                state_d     = UPD_WR;
            end
            UPD_WR: begin
                fetch_stall = lookup_req;
                tbl_en      = 1'b1;
                tbl_we      = 1'b1;
                tbl_idx     = IDX_W'(head.idx);
                tbl_wdata   = {cho_nxt, glb_nxt, loc_nxt};
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        age_d   = age_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Head ages only while fetch keeps winning the port
        if (pop) begin
            age_d = '0;
        end else if (queued && lookup_grant && age_q < AGE_W'(AGE_MAX)) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
            rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
            rd_q    <= rd_d;
            if (push) begin
                fifo_q[tail_q] <= upd_in;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler with a behavioural table RAM.
module tb_bp_update_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lookup_req = 1'b0;
    logic [4:0] lookup_idx = '0;
    logic       lookup_grant;
    logic       fetch_stall;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [4:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_local_ok = 1'b0;
    logic       upd_global_ok = 1'b0;
    logic       tbl_en;
    logic       tbl_we;
    logic [4:0] tbl_idx;
    logic [5:0] tbl_wdata;
    logic [5:0] tbl_rdata = '0;
    logic       busy;

    typedef struct {
        logic [4:0] idx;
        logic [5:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] mem[32];
    logic [5:0] model[32];
    int         n_tests = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;

    always #5 clk = ~clk;

    bp_update_scheduler #(
        .IDX_W   (5),
        .DEPTH   (4),
        .AGE_MAX (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_req    (lookup_req),
        .lookup_idx    (lookup_idx),
        .lookup_grant  (lookup_grant),
        .fetch_stall   (fetch_stall),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .upd_local_ok  (upd_local_ok),
        .upd_global_ok (upd_global_ok),
        .tbl_en        (tbl_en),
        .tbl_we        (tbl_we),
        .tbl_idx       (tbl_idx),
        .tbl_wdata     (tbl_wdata),
        .tbl_rdata     (tbl_rdata),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c,
                                       input bit up, input bit dn);
        if (up && !dn) return (c == 2'd3) ? c : c + 2'd1;
        if (dn && !up) return (c == 2'd0) ? c : c - 2'd1;
        return c;
    endfunction

    // Synchronous single-port table RAM
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_idx] <= tbl_wdata;
            else        tbl_rdata <= mem[tbl_idx];
        end
    end

    always @(negedge clk) begin
        if (rst_n && tbl_en && tbl_we) begin
            exp_t e;
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexp_wr", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_idx", 32'(tbl_idx), 32'(e.idx));
                chk("wr_data", 32'(tbl_wdata), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic [4:0] idx, input logic [5:0] v);
        mem[idx]   = v;
        model[idx] = v;
    endtask

    task automatic push(input logic [4:0] idx, input bit tk,
                        input bit lok, input bit gok);
        logic [5:0] m;
        exp_t       e;
        m = model[idx];
        e.idx  = idx;
        e.data = {sat(m[5:4], gok && !lok, lok && !gok),
                  sat(m[3:2], tk, !tk),
                  sat(m[1:0], tk, !tk)};
        model[idx] = e.data;
        sb.push_back(e);
        chk("push_ready", 32'(upd_ready), 32'd1);
        upd_valid     = 1'b1;
        upd_idx       = idx;
        upd_taken     = tk;
        upd_local_ok  = lok;
        upd_global_ok = gok;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) step();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int grants;
        int wr0;
        for (int i = 0; i < 32; i++) set_mem(5'(i), 6'(i * 7));

        step();
        step();
        chk("rst_ready", 32'(upd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(tbl_en), 32'd0);
        chk("rst_grant", 32'(lookup_grant), 32'd0);
        chk("rst_stall", 32'(fetch_stall), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic update, no lookups
        set_mem(5, 6'b01_01_01);
        push(5, 1, 0, 1);
        chk("b_rd_en", 32'({tbl_en, tbl_we}), 32'b10);
        chk("b_rd_idx", 32'(tbl_idx), 32'd5);
        step();
        chk("b_idle_port", 32'(tbl_en), 32'd0);
        step();
        chk("b_wr_we", 32'(tbl_we), 32'd1);
        chk("b_wr_data", 32'(tbl_wdata), 32'b10_10_10);
        wait_idle();

        // Saturation at both ends
        set_mem(7, 6'b11_11_11);
        push(7, 1, 0, 1);
        step();
        step();
        chk("sat_hi", 32'(tbl_wdata), 32'b11_11_11);
        wait_idle();
        set_mem(8, 6'b00_00_00);
        push(8, 0, 1, 0);
        step();
        step();
        chk("sat_lo_we", 32'(tbl_we), 32'd1);
        chk("sat_lo", 32'(tbl_wdata), 32'd0);
        wait_idle();

        // Fill while fetch holds the port
        lookup_req = 1'b1;
        lookup_idx = 5'd3;
        push(10, 1, 1, 0);
        push(11, 0, 0, 1);
        push(12, 1, 0, 0);
        push(13, 0, 1, 1);
        chk("full_ready", 32'(upd_ready), 32'd0);
        chk("full_stall1", 32'(fetch_stall), 32'd1);
        chk("full_grant", 32'(lookup_grant), 32'd0);
        chk("full_rd_idx", 32'(tbl_idx), 32'd10);
        step();
        chk("full_stall2", 32'(fetch_stall), 32'd1);
        step();
        chk("full_stall3", 32'(fetch_stall), 32'd1);
        chk("full_wr", 32'(tbl_we), 32'd1);
        step();
        chk("full_stall_end", 32'(fetch_stall), 32'd0);
        chk("full_regrant", 32'(lookup_grant), 32'd1);
        chk("full_ready_back", 32'(upd_ready), 32'd1);
        lookup_req = 1'b0;
        wait_idle();

        // Aging of a single queued entry
        lookup_req = 1'b1;
        push(20, 1, 1, 1);
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            if (lookup_grant) grants++;
            step();
        end
        chk("age_grants", 32'(grants), 32'd8);
        chk("age_stall", 32'(fetch_stall), 32'd1);
        chk("age_rd", 32'({tbl_en, tbl_we}), 32'b10);
        chk("age_idx", 32'(tbl_idx), 32'd20);
        lookup_req = 1'b0;
        wait_idle();

        // Back-to-back updates to one index
        set_mem(2, 6'b00_00_00);
        push(2, 1, 1, 1);
        push(2, 1, 1, 1);
        step();
        chk("b2b_wr1", 32'({tbl_we, tbl_wdata[1:0]}), 32'b1_01);
        step();
        step();
        step();
        chk("b2b_wr2", 32'({tbl_we, tbl_wdata[1:0]}), 32'b1_10);
        wait_idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Reset with three entries queued
        lookup_req = 1'b1;
        push(14, 1, 0, 1);
        push(15, 0, 1, 0);
        push(16, 1, 1, 1);
        rst_n      = 1'b0;
        lookup_req = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(upd_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        for (int i = 0; i < 32; i++) model[i] = mem[i];
        step();
        step();
        rst_n = 1'b1;
        wr0   = wr_cnt;
        for (int i = 0; i < 10; i++) step();
        chk("no_wr_after_rst", 32'(wr_cnt - wr0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
